// File: rtl/aclk_pkg.sv
// Shared constants, FSM/mode encodings and BCD-to-ASCII helper for the
// alarm-clock LCD scan block.
package aclk_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_t;

    // Which source is on the display; only MODE_KEY blinks.
    typedef enum logic [1:0] {
        MODE_TIME,
        MODE_KEY,
        MODE_ALARM
    } mode_t;

    // Non-decimal nibbles show as a dash so a half-typed key entry is obvious.
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            return ASCII_ZERO + {4'h0, digit};
        end
        return ASCII_DASH;
    endfunction

endpackage

// File: rtl/aclk_alarm_latch.sv
// Alarm latch: fires on the rising edge of current_time == alarm_time and
// holds until stop_alarm; a held match cannot re-trigger after a stop.
module aclk_alarm_latch #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] current_time,
    input  logic [WIDTH-1:0] alarm_time,
    input  logic             stop_alarm,
    output logic             sound_alarm
);

    logic match_now;
    logic match_q;
    logic set_alarm;

    assign match_now = (current_time == alarm_time);
    assign set_alarm = match_now & ~match_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_q     <= 1'b0;
            sound_alarm <= 1'b0;
        end else begin
            match_q <= match_now;
            if (stop_alarm) begin
                sound_alarm <= 1'b0;
            end else if (set_alarm) begin
                sound_alarm <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/aclk_lcd_scan.sv
// Multi-digit LCD scan: picks alarm/key/current time, snapshots it per frame
// and streams one ASCII character per digit over a valid/ready handshake.
module aclk_lcd_scan
    import aclk_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int BLINK_TICKS = 2
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             show_a,
    input  logic                                             show_new_time,
    input  logic [4*NUM_DIGITS-1:0]                          alarm_time,
    input  logic [4*NUM_DIGITS-1:0]                          current_time,
    input  logic [4*NUM_DIGITS-1:0]                          key,
    input  logic                                             refresh_tick,
    input  logic                                             stop_alarm,
    input  logic                                             lcd_ready,
    output logic                                             lcd_valid,
    output logic [7:0]                                       lcd_char,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] lcd_pos,
    output logic                                             frame_done,
    output logic                                             sound_alarm
);

    localparam int POS_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int VAL_W   = 4 * NUM_DIGITS;

    localparam logic [POS_W-1:0]   LAST_POS   = POS_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("aclk_lcd_scan: NUM_DIGITS must be in 1..8");
    end
    if (BLINK_TICKS < 1) begin : g_bad_blink_ticks
        $error("aclk_lcd_scan: BLINK_TICKS must be >= 1");
    end

    state_t             state;
    state_t             state_next;

    logic [VAL_W-1:0]   sel_val;
    mode_t              sel_mode;
    logic [VAL_W-1:0]   prev_val;
    mode_t              prev_mode;
    logic               request;
    logic               pending;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    logic [VAL_W-1:0]   snap_val;
    logic               snap_blank;
    logic [POS_W-1:0]   pos;
    logic [POS_W-1:0]   digit_idx;
    logic [3:0]         cur_digit;

    // Source select: alarm beats key entry beats current time.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sel_val  = current_time;
        sel_mode = MODE_TIME;
        if (show_a) begin
            sel_val  = alarm_time;
            sel_mode = MODE_ALARM;
        end else if (show_new_time) begin
            sel_val  = key;
            sel_mode = MODE_KEY;
        end
    end

    assign request = refresh_tick | (sel_val != prev_val) | (sel_mode != prev_mode);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (request || pending) state_next = LOAD;
            LOAD:    state_next = SEND;
            SEND:    if (lcd_ready && pos == LAST_POS) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Change detection, single-deep pending request and blink timing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_val  <= '0;
            prev_mode <= MODE_TIME;
            pending   <= 1'b1;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            prev_val  <= sel_val;
            prev_mode <= sel_mode;

            if (state == IDLE) begin
                pending <= 1'b0;
            end else if (request) begin
                pending <= 1'b1;
            end

            if (sel_mode != MODE_KEY) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (refresh_tick) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

    // Frame snapshot and position; the frame is immune to source changes
    // once LOAD has captured it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_val   <= '0;
            snap_blank <= 1'b0;
            pos        <= '0;
        end else begin
            case (state)
                LOAD: begin
                    snap_val   <= sel_val;
                    snap_blank <= (sel_mode == MODE_KEY) && !blink_on;
                    pos        <= '0;
                end
                SEND: begin
                    if (lcd_ready && pos != LAST_POS) begin
                        pos <= pos + POS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Position 0 is the most significant digit.
    always_comb begin
        digit_idx = LAST_POS - pos;
        cur_digit = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == POS_W'(i)) begin
                cur_digit = snap_val[4*i +: 4];
            end
        end
    end

    always_comb begin
        lcd_valid  = 1'b0;
        frame_done = 1'b0;
        lcd_char   = ASCII_SPACE;
        case (state)
            SEND: begin
                lcd_valid = 1'b1;
                lcd_char  = snap_blank ? ASCII_SPACE : bcd_to_ascii(cur_digit);
            end
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    assign lcd_pos = pos;

    aclk_alarm_latch #(
        .WIDTH (VAL_W)
    ) u_alarm_latch (
        .clk          (clk),
        .reset        (reset),
        .current_time (current_time),
        .alarm_time   (alarm_time),
        .stop_alarm   (stop_alarm),
        .sound_alarm  (sound_alarm)
    );

endmodule
